aes_key_arbiter: RTL and testbench

- Shares one aes_key_expander between the AES encrypt core and the AES decrypt core.
- Accepts round-key requests (key_req/key_sel) from both cores and arbitrates them round-robin.
- Issues one request at a time to the expander and registers the returned round key.
- Delivers the key to the granted core with a single-cycle valid pulse. Sits between the two cores and the expander in the crypto processor top.

---
 rtl/aes_key_arbiter_pkg.sv | 23 ++
 rtl/aes_key_arbiter_if.sv | 39 +++
 rtl/aes_key_arbiter_rr_arb2.sv | 39 +++
 rtl/aes_key_arbiter.sv | 137 +++++++++++++
 tb/tb_aes_key_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_arbiter_pkg.sv
// Shared types for the AES round-key arbiter: FSM states, requester IDs, round-key word.
// Pure type/constant package, no logic, no latency.
package aes_key_arb_pkg;

   localparam int NO_ROWS   = 4;
   localparam int NO_COLS   = 4;
   localparam int KEY_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DELIVER,
      ERR
   } state_t;

   typedef enum logic {
      REQ_ENC,
      REQ_DEC
   } req_id_t;

   typedef logic [7:0][NO_ROWS-1:0][NO_COLS-1:0] round_key_t;

endpackage

// File: rtl/aes_key_arbiter_if.sv
// Bundle of core-side and expander-side signals around the key arbiter.
// slave = arbiter view, master = surrounding cores/expander view.
interface aes_key_arb_if;
   import aes_key_arb_pkg::*;

   logic                 enc_key_req_i;
   logic [KEY_SEL_W-1:0] enc_key_sel_i;
   logic                 enc_key_vld_o;
   logic                 enc_key_err_o;
   round_key_t           enc_round_key_o;

   logic                 dec_key_req_i;
   logic [KEY_SEL_W-1:0] dec_key_sel_i;
   logic                 dec_key_vld_o;
   logic                 dec_key_err_o;
   round_key_t           dec_round_key_o;

   logic                 key_req_o;
   logic [KEY_SEL_W-1:0] key_sel_o;
   logic                 key_rdy_i;
   round_key_t           round_key_i;

   modport slave (
      input  enc_key_req_i, enc_key_sel_i, dec_key_req_i, dec_key_sel_i,
      input  key_rdy_i, round_key_i,
      output enc_key_vld_o, enc_key_err_o, enc_round_key_o,
      output dec_key_vld_o, dec_key_err_o, dec_round_key_o,
      output key_req_o, key_sel_o
   );

   modport master (
      output enc_key_req_i, enc_key_sel_i, dec_key_req_i, dec_key_sel_i,
      output key_rdy_i, round_key_i,
      input  enc_key_vld_o, enc_key_err_o, enc_round_key_o,
      input  dec_key_vld_o, dec_key_err_o, dec_round_key_o,
      input  key_req_o, key_sel_o
   );

endinterface

// File: rtl/aes_key_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips away from the winner on advance.
// Zero latency grant; no backpressure, caller decides when to advance.
module aes_rr_arb2
   import aes_key_arb_pkg::*;
(
   input  logic       aes_clk,
   input  logic       resetn,
   input  logic [1:0] i_req,
   input  logic       i_adv,
   output logic [1:0] o_gnt,
   output req_id_t    o_gnt_id
);

   req_id_t r_ptr;
   req_id_t w_gnt_id;

   always_comb begin
      if (i_req == 2'b11) begin
         w_gnt_id = r_ptr;
      end else if (i_req[1]) begin
         w_gnt_id = REQ_DEC;
      end else begin
         w_gnt_id = REQ_ENC;
      end
   end

   assign o_gnt_id = w_gnt_id;
   assign o_gnt    = (i_req == 2'b00) ? 2'b00 :
                     (w_gnt_id == REQ_DEC) ? 2'b10 : 2'b01;

   always_ff @(posedge aes_clk or negedge resetn) begin
      if (!resetn) begin
         r_ptr <= REQ_ENC;
      end else if (i_adv && (i_req != 2'b00)) begin
         r_ptr <= (w_gnt_id == REQ_ENC) ? REQ_DEC : REQ_ENC;
      end
   end

endmodule

// File: rtl/aes_key_arbiter.sv
// Shares one key expander between encrypt/decrypt cores; req->key_req 1 cycle, rdy->vld 1 cycle.
// Requesters hold req until vld/err; optional watchdog via AES_KEY_ARB_TIMEOUT_EN.
module aes_key_arbiter
   import aes_key_arb_pkg::*;
#(
   parameter int NUM_ROUNDS = 10
`ifdef AES_KEY_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic         aes_clk,
   input  logic         resetn,
   aes_key_arb_if.slave bus
);

   localparam logic [KEY_SEL_W-1:0] MAX_SEL = KEY_SEL_W'(NUM_ROUNDS);

   state_t               r_state;
   state_t               w_next;
   req_id_t              r_gnt_id;
   req_id_t              w_gnt_id;
   logic [KEY_SEL_W-1:0] r_sel;
   logic [KEY_SEL_W-1:0] w_sel_in;
   logic [1:0]           w_gnt;
   logic                 w_grant;
   logic                 w_wd_expired;
   round_key_t           r_enc_key;
   round_key_t           r_dec_key;

   aes_rr_arb2 u_rr_arb2 (
      .aes_clk  (aes_clk),
      .resetn   (resetn),
      .i_req    ({bus.dec_key_req_i, bus.enc_key_req_i}),
      .i_adv    (r_state == IDLE),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id)
   );

   assign w_grant  = |w_gnt;
   assign w_sel_in = (w_gnt_id == REQ_DEC) ? bus.dec_key_sel_i : bus.enc_key_sel_i;

`ifdef AES_KEY_ARB_TIMEOUT_EN
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_wd;

   // Counter is zero on the first WAIT cycle because it is held clear outside WAIT.
   always_ff @(posedge aes_clk or negedge resetn) begin
      if (!resetn) begin
         r_wd <= 8'd0;
      end else if (r_state != WAIT) begin
         r_wd <= 8'd0;
      end else begin
         r_wd <= r_wd + 8'd1;
      end
   end

   assign w_wd_expired = (r_wd == WD_LIMIT);
`else
   assign w_wd_expired = 1'b0;
`endif

   always_ff @(posedge aes_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A rdy in the same cycle as watchdog expiry takes priority.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_next = (w_sel_in > MAX_SEL) ? ERR : WAIT;
         WAIT: begin
            if (bus.key_rdy_i) begin
               w_next = DELIVER;
            end else if (w_wd_expired) begin
               w_next = ERR;
            end
         end
         DELIVER: w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge aes_clk or negedge resetn) begin
      if (!resetn) begin
         r_gnt_id  <= REQ_ENC;
         r_sel     <= '0;
         r_enc_key <= '0;
         r_dec_key <= '0;
      end else begin
         if ((r_state == IDLE) && w_grant) begin
            r_gnt_id <= w_gnt_id;
            r_sel    <= w_sel_in;
         end
         if ((r_state == WAIT) && bus.key_rdy_i) begin
            if (r_gnt_id == REQ_ENC) begin
               r_enc_key <= bus.round_key_i;
            end else begin
               r_dec_key <= bus.round_key_i;
            end
         end
      end
   end

   always_comb begin
      bus.key_req_o     = 1'b0;
      bus.key_sel_o     = '0;
      bus.enc_key_vld_o = 1'b0;
      bus.dec_key_vld_o = 1'b0;
      bus.enc_key_err_o = 1'b0;
      bus.dec_key_err_o = 1'b0;
      case (r_state)
         WAIT: begin
            bus.key_req_o = 1'b1;
            bus.key_sel_o = r_sel;
         end
         DELIVER: begin
            bus.enc_key_vld_o = (r_gnt_id == REQ_ENC);
            bus.dec_key_vld_o = (r_gnt_id == REQ_DEC);
         end
         ERR: begin
            bus.enc_key_err_o = (r_gnt_id == REQ_ENC);
            bus.dec_key_err_o = (r_gnt_id == REQ_DEC);
         end
         default: ;
      endcase
   end

   assign bus.enc_round_key_o = r_enc_key;
   assign bus.dec_round_key_o = r_dec_key;

endmodule

// File: tb/tb_aes_key_arbiter.sv
// Bench for aes_key_arbiter: directed scenarios plus randomized traffic against a cycle-count model.
module tb_aes_key_arbiter;
   import aes_key_arb_pkg::*;

   localparam int T_CYC = 8;

   logic aes_clk;
   logic resetn = 1'b0;

   aes_key_arb_if bus ();

`ifdef AES_KEY_ARB_TIMEOUT_EN
   aes_key_arbiter #(.NUM_ROUNDS(10), .TIMEOUT_CYCLES(T_CYC)) dut (
      .aes_clk(aes_clk), .resetn(resetn), .bus(bus)
   );
`else
   aes_key_arbiter #(.NUM_ROUNDS(10)) dut (
      .aes_clk(aes_clk), .resetn(resetn), .bus(bus)
   );
`endif

   initial begin
      aes_clk = 1'b0;
      forever #5 aes_clk = ~aes_clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   round_key_t tab [0:15];

   function automatic logic [3:0] rsel();
      return 4'($urandom_range(0, 12));
   endfunction

   // ---------------- reference model: grant order and cycle arithmetic ----------------
   int         m_edge, m_free, m_g, m_ptr, m_who, m_sel;
   bit         m_wait;
   bit   [1:0] e_vld, e_err;
   bit         e_req;
   logic [3:0] e_sel;
   round_key_t e_key [2];

   task automatic m_clear();
      m_edge = 0; m_free = 0; m_g = 0; m_ptr = 0; m_wait = 0;
      e_vld = 0; e_err = 0; e_req = 0; e_sel = 0;
      e_key[0] = '0; e_key[1] = '0;
   endtask

   initial begin
      m_clear();
      forever begin
         @(posedge aes_clk or negedge resetn);
         if (!resetn) begin
            m_clear();
         end else begin
            m_edge++;
            e_vld = 0; e_err = 0; e_req = 0; e_sel = 0;
            if (m_wait) begin
               if (bus.key_rdy_i) begin
                  e_key[m_who] = bus.round_key_i;
                  e_vld[m_who] = 1'b1;
                  m_wait = 0;
                  m_free = m_edge + 2;
`ifdef AES_KEY_ARB_TIMEOUT_EN
               end else if (m_edge - m_g == T_CYC) begin
                  e_err[m_who] = 1'b1;
                  m_wait = 0;
                  m_free = m_edge + 2;
`endif
               end else begin
                  e_req = 1'b1;
                  e_sel = 4'(m_sel);
               end
            end else if (m_edge >= m_free && (bus.enc_key_req_i || bus.dec_key_req_i)) begin
               if (bus.enc_key_req_i && bus.dec_key_req_i) m_who = m_ptr;
               else m_who = bus.dec_key_req_i ? 1 : 0;
               m_ptr = 1 - m_who;
               m_sel = (m_who == 1) ? int'(bus.dec_key_sel_i) : int'(bus.enc_key_sel_i);
               if (m_sel > 10) begin
                  e_err[m_who] = 1'b1;
                  m_free = m_edge + 2;
               end else begin
                  m_wait = 1;
                  m_g = m_edge;
                  e_req = 1'b1;
                  e_sel = 4'(m_sel);
               end
            end
         end
      end
   end

   // ---------------- every-cycle compare ----------------
   initial begin
      forever begin
         @(negedge aes_clk);
         chk("enc_vld", bus.enc_key_vld_o, e_vld[0]);
         chk("dec_vld", bus.dec_key_vld_o, e_vld[1]);
         chk("enc_err", bus.enc_key_err_o, e_err[0]);
         chk("dec_err", bus.dec_key_err_o, e_err[1]);
         chk("key_req", bus.key_req_o, e_req);
         chk("key_sel", bus.key_sel_o, e_sel);
         chk("enc_key", bus.enc_round_key_o, e_key[0]);
         chk("dec_key", bus.dec_round_key_o, e_key[1]);
      end
   end

   // ---------------- expander stand-in ----------------
   int exp_mode = 0;   // 0 responds after exp_delay cycles, 1 never responds
   int exp_delay = 0;
   int w_cnt = 0;
   bit exp_rand = 0;
   bit spur_en = 0;

   initial begin
      bus.key_rdy_i   = 1'b0;
      bus.round_key_i = '0;
      forever begin
         @(negedge aes_clk);
         bus.key_rdy_i = 1'b0;
         if (bus.key_req_o && exp_mode == 0) begin
            if (w_cnt >= exp_delay) begin
               bus.key_rdy_i   = 1'b1;
               bus.round_key_i = tab[bus.key_sel_o];
               w_cnt = 0;
               if (exp_rand) exp_delay = int'($urandom_range(0, 3));
            end else begin
               w_cnt++;
            end
         end else begin
            w_cnt = 0;
            if (!bus.key_req_o && spur_en && ($urandom_range(0, 7) == 0)) begin
               bus.key_rdy_i   = 1'b1;
               bus.round_key_i = {$urandom, $urandom, $urandom, $urandom};
            end
         end
      end
   end

   // ---------------- random requesters ----------------
   bit rand_en = 0;

   initial begin
      forever begin
         @(negedge aes_clk);
         if (rand_en) begin
            if (bus.enc_key_vld_o || bus.enc_key_err_o) begin
               bus.enc_key_req_i = 1'($urandom_range(0, 1));
               bus.enc_key_sel_i = rsel();
            end else if (!bus.enc_key_req_i && $urandom_range(0, 3) == 0) begin
               bus.enc_key_req_i = 1'b1;
               bus.enc_key_sel_i = rsel();
            end else if ($urandom_range(0, 31) == 0) begin
               bus.enc_key_sel_i = rsel();
            end else if ($urandom_range(0, 63) == 0) begin
               bus.enc_key_req_i = 1'b0;
            end
            if (bus.dec_key_vld_o || bus.dec_key_err_o) begin
               bus.dec_key_req_i = 1'($urandom_range(0, 1));
               bus.dec_key_sel_i = rsel();
            end else if (!bus.dec_key_req_i && $urandom_range(0, 3) == 0) begin
               bus.dec_key_req_i = 1'b1;
               bus.dec_key_sel_i = rsel();
            end else if ($urandom_range(0, 31) == 0) begin
               bus.dec_key_sel_i = rsel();
            end else if ($urandom_range(0, 63) == 0) begin
               bus.dec_key_req_i = 1'b0;
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   // kind: 0 enc vld, 1 dec vld, 2 enc err, 3 dec err
   task automatic wait_sig(input int kind, input int limit, output int n);
      bit hit;
      hit = 0; n = 0;
      while (!hit && n < limit) begin
         @(negedge aes_clk);
         n++;
         case (kind)
            0: hit = bus.enc_key_vld_o;
            1: hit = bus.dec_key_vld_o;
            2: hit = bus.enc_key_err_o;
            default: hit = bus.dec_key_err_o;
         endcase
      end
      if (!hit) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_sig%0d: no pulse within %0d cycles, required one", kind, limit);
      end
   endtask

   task automatic wait_any(input int limit, output int who);
      int n;
      who = -1; n = 0;
      while (who < 0 && n < limit) begin
         @(negedge aes_clk);
         n++;
         if (bus.enc_key_vld_o) who = 0;
         else if (bus.dec_key_vld_o) who = 1;
      end
      if (who < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_any: no vld within %0d cycles, required one", limit);
      end
   endtask

   task automatic do_reset();
      @(negedge aes_clk);
      resetn = 1'b0;
      @(negedge aes_clk);
      resetn = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n, who, saw_err;
      bus.enc_key_req_i = 1'b0; bus.enc_key_sel_i = '0;
      bus.dec_key_req_i = 1'b0; bus.dec_key_sel_i = '0;
      tab[0] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
      for (int i = 1; i < 16; i++) tab[i] = {$urandom, $urandom, $urandom, $urandom};

      repeat (3) @(negedge aes_clk);
      chk("rst_key_req", bus.key_req_o, 1'b0);
      chk("rst_enc_key", bus.enc_round_key_o, 128'h0);
      chk("rst_dec_vld", bus.dec_key_vld_o, 1'b0);
      resetn = 1'b1;

      // encrypt-only, expander answers after 3 cycles
      exp_mode = 0; exp_delay = 3;
      @(negedge aes_clk);
      bus.enc_key_req_i = 1'b1; bus.enc_key_sel_i = 4'd0;
      wait_sig(0, 20, n);
      chk("t1_latency", n, 5);
      chk("t1_enc_key", bus.enc_round_key_o, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
      chk("t1_dec_key", bus.dec_round_key_o, 128'h0);
      bus.enc_key_req_i = 1'b0;
      @(negedge aes_clk);
      chk("t1_req_drop", bus.key_req_o, 1'b0);
      chk("t1_one_pulse", bus.enc_key_vld_o, 1'b0);

      // simultaneous after reset: enc, dec, then enc re-request loses to pending dec? no: dec next
      do_reset();
      exp_delay = 0;
      @(negedge aes_clk);
      bus.enc_key_req_i = 1'b1; bus.enc_key_sel_i = 4'd1;
      bus.dec_key_req_i = 1'b1; bus.dec_key_sel_i = 4'd10;
      wait_any(20, who);
      chk("t2_first_enc", who, 0);
      chk("t2_enc_key1", bus.enc_round_key_o, tab[1]);
      bus.enc_key_sel_i = 4'd2;
      wait_any(20, who);
      chk("t2_second_dec", who, 1);
      chk("t2_dec_key10", bus.dec_round_key_o, tab[10]);
      bus.dec_key_req_i = 1'b0;
      wait_any(20, who);
      chk("t2_third_enc", who, 0);
      bus.enc_key_req_i = 1'b0;

      // decrypt sweep 10..0 with zero-wait expander
      @(negedge aes_clk);
      bus.dec_key_req_i = 1'b1; bus.dec_key_sel_i = 4'd10;
      for (int s = 10; s >= 0; s--) begin
         wait_sig(1, 20, n);
         chk("t3_key", bus.dec_round_key_o, tab[s]);
         if (s < 10) chk("t3_spacing", n, 3);
         if (s > 0) bus.dec_key_sel_i = 4'(s - 1);
         else bus.dec_key_req_i = 1'b0;
      end

      // illegal index
      @(negedge aes_clk);
      bus.enc_key_req_i = 1'b1; bus.enc_key_sel_i = 4'd11;
      wait_sig(2, 5, n);
      chk("t4_err_lat", n, 1);
      chk("t4_no_req", bus.key_req_o, 1'b0);
      chk("t4_key_kept", bus.enc_round_key_o, tab[2]);
      bus.enc_key_req_i = 1'b0;
      @(negedge aes_clk);
      chk("t4_err_once", bus.enc_key_err_o, 1'b0);
      chk("t4_no_req2", bus.key_req_o, 1'b0);

      // reset while waiting on the expander
      exp_mode = 1;
      bus.enc_key_req_i = 1'b1; bus.enc_key_sel_i = 4'd3;
      @(negedge aes_clk);
      @(negedge aes_clk);
      chk("t5_in_wait", bus.key_req_o, 1'b1);
      bus.enc_key_req_i = 1'b0;
      @(posedge aes_clk);
      #2 resetn = 1'b0;
      #1;
      chk("t5_rst_req", bus.key_req_o, 1'b0);
      chk("t5_rst_sel", bus.key_sel_o, 4'd0);
      chk("t5_rst_enc", bus.enc_round_key_o, 128'h0);
      chk("t5_rst_dec", bus.dec_round_key_o, 128'h0);
      @(negedge aes_clk);
      resetn = 1'b1;
      exp_mode = 0; exp_delay = 1;
      @(negedge aes_clk);
      bus.enc_key_req_i = 1'b1; bus.enc_key_sel_i = 4'd6;
      bus.dec_key_req_i = 1'b1; bus.dec_key_sel_i = 4'd5;
      wait_any(20, who);
      chk("t5_ptr_enc", who, 0);
      bus.enc_key_req_i = 1'b0;
      wait_any(20, who);
      chk("t5_dec_served", who, 1);
      chk("t5_dec_key5", bus.dec_round_key_o, tab[5]);
      bus.dec_key_req_i = 1'b0;

      // randomized traffic
      exp_rand = 1; spur_en = 1; rand_en = 1;
      repeat (3000) @(negedge aes_clk);
      rand_en = 0; spur_en = 0;
      @(negedge aes_clk);
      bus.enc_key_req_i = 1'b0; bus.dec_key_req_i = 1'b0;
      repeat (20) @(negedge aes_clk);
      exp_rand = 0;

      // expander never answers
      exp_mode = 1;
      @(negedge aes_clk);
      bus.enc_key_req_i = 1'b1; bus.enc_key_sel_i = 4'd4;
`ifdef AES_KEY_ARB_TIMEOUT_EN
      wait_sig(2, 30, n);
      chk("t7_timeout_lat", n, T_CYC + 1);
      chk("t7_req_dropped", bus.key_req_o, 1'b0);
      bus.enc_key_req_i = 1'b0;
      @(negedge aes_clk);
`else
      saw_err = 0;
      repeat (100) begin
         @(negedge aes_clk);
         if (bus.enc_key_err_o) saw_err = 1;
      end
      chk("t7_still_wait", bus.key_req_o, 1'b1);
      chk("t7_no_err", saw_err, 0);
      bus.enc_key_req_i = 1'b0;
      do_reset();
`endif
      repeat (2) @(negedge aes_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
